// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//
// Drives a multiplexed six-position seven-segment display from a shadow copy of up to six
// BCD digits plus decimal-point flags. The shadow is captured on a load strobe. A
// free-running prescaler paces the position scan. Leading-zero blanking is optional.
//
// Parameters:
//   NUM_DIGITS  number of active positions (1..6), always the rightmost ones
//   SCAN_DIV    prescaler width; the scan advances once every 2^SCAN_DIV clk cycles
//   BLANK_LZ    1 = blank leading zeros, 0 = show every digit
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   load        capture strobe for digits_in/dp_in
//   digits_in   six BCD digits, digit k at [4k+3:4k], digit 0 rightmost
//   dp_in       decimal point per digit, bit k belongs to digit k
//   seg7_sel    active position, 3'b101 rightmost, decreasing leftward
//   seg7_out    segments {a,b,c,d,e,f,g}, active-high
//   dpt_out     decimal point of the active position, active-high
//   led_com     display common, tied high
//   frame_done  one-clk pulse when the scan wraps back to the rightmost position

module seg7_scan_driver #(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned SCAN_DIV   = 17,
  parameter int unsigned BLANK_LZ   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [23:0] digits_in,
  input  logic [5:0]  dp_in,
  output logic [2:0]  seg7_sel,
  output logic [6:0]  seg7_out,
  output logic        dpt_out,
  output logic        led_com,
  output logic        frame_done
);

  // Rightmost position, and the leftmost active one where the scan wraps.
  localparam logic [2:0] SelRight = 3'd5;
  localparam logic [2:0] SelLeft  = 3'(6 - NUM_DIGITS);

  // ---------------------------------------------------------------------------
  // Shadow register
  // ---------------------------------------------------------------------------
  logic [23:0] shadow_digits_q, shadow_digits_d;
  logic [5:0]  shadow_dp_q, shadow_dp_d;

  always_comb begin
    shadow_digits_d = shadow_digits_q;
    shadow_dp_d     = shadow_dp_q;
    if (load) begin
      shadow_digits_d = digits_in;
      shadow_dp_d     = dp_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_digits_q <= '0;
      shadow_dp_q     <= '0;
    end else begin
      shadow_digits_q <= shadow_digits_d;
      shadow_dp_q     <= shadow_dp_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Prescaler
  // ---------------------------------------------------------------------------
  logic [SCAN_DIV-1:0] presc_q, presc_d;
  logic                tick;

  // Tick on the all-ones count; the counter then rolls over to zero by itself.
  assign tick    = &presc_q;
  assign presc_d = presc_q + SCAN_DIV'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Position scan
  // ---------------------------------------------------------------------------
  logic [2:0] sel_q, sel_d;
  logic       frame_done_q, frame_done_d;

  always_comb begin
    sel_d        = sel_q;
    frame_done_d = 1'b0;
    if (tick) begin
      if (sel_q == SelLeft) begin
        sel_d        = SelRight;
        frame_done_d = 1'b1;
      end else begin
        sel_d = sel_q - 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q        <= SelRight;
      frame_done_q <= 1'b0;
    end else begin
      sel_q        <= sel_d;
      frame_done_q <= frame_done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Digit select, blanking and decode
  // ---------------------------------------------------------------------------
  logic [2:0] pos;
  logic [3:0] digit;
  logic       dp_sel;
  logic [7:0] upper_zero;
  logic       blank;

  // Digit index counted from the right; sel never leaves 5..(6-NUM_DIGITS).
  assign pos = SelRight - sel_q;

  always_comb begin
    digit  = 4'd0;
    dp_sel = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (pos == 3'(k)) begin
        digit  = shadow_digits_q[4*k +: 4];
        dp_sel = shadow_dp_q[k];
      end
    end
  end

  // upper_zero[k]: every active digit from k up to the leftmost active one is 4'd0.
  // Codes 10..15 are not zero, so they stop the blanking run. Inactive digits are skipped.
  always_comb begin
    logic run;
    run        = 1'b1;
    upper_zero = '0;
    for (int k = 5; k >= 0; k--) begin
      if (k < int'(NUM_DIGITS)) begin
        run           = run & (shadow_digits_q[4*k +: 4] == 4'd0);
        upper_zero[k] = run;
      end
    end
  end

  assign blank = (BLANK_LZ != 0) && (pos != 3'd0) && upper_zero[pos];

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  always_comb begin
    seg7_out = bcd_to_seg(digit);
    if (blank) begin
      seg7_out = 7'b0000000;
    end
  end

  // The decimal point is deliberately left visible on blanked positions.
  assign dpt_out    = dp_sel;
  assign seg7_sel   = sel_q;
  assign frame_done = frame_done_q;
  assign led_com    = 1'b1;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: four instances with different NUM_DIGITS/BLANK_LZ share one
// stimulus stream. The stimulus pushes the expected outputs of every instance into a
// queue, and a monitor pops and compares them once per cycle on the falling edge.

module tb_seg7_scan_driver;

  localparam int unsigned ScanDiv = 2;
  localparam int          Period  = 1 << ScanDiv;
  localparam int          NumDut  = 4;

  typedef struct packed {
    logic [2:0] sel;
    logic [6:0] seg;
    logic       dpt;
    logic       fd;
    logic       com;
  } exp_t;

  typedef exp_t [NumDut-1:0] exp_set_t;

  logic        clk;
  logic        reset;
  logic        load;
  logic [23:0] digits_in;
  logic [5:0]  dp_in;

  logic [2:0] sel_o   [NumDut];
  logic [6:0] seg_o   [NumDut];
  logic       dpt_o   [NumDut];
  logic       com_o   [NumDut];
  logic       fd_o    [NumDut];

  int checks   = 0;
  int failures = 0;

  exp_set_t exp_q[$];

  // Reference state: rising edges since reset release and the last captured data.
  int unsigned cyc;
  logic [23:0] sh_d;
  logic [5:0]  sh_dp;

  function automatic int nd_of(input int i);
    return (i == 2) ? 2 : ((i == 3) ? 1 : 6);
  endfunction

  function automatic bit blz_of(input int i);
    return (i != 1);
  endfunction

  for (genvar i = 0; i < NumDut; i++) begin : g_dut
    localparam int unsigned Nd  = (i == 2) ? 2 : ((i == 3) ? 1 : 6);
    localparam int unsigned Blz = (i == 1) ? 0 : 1;
    seg7_scan_driver #(
      .NUM_DIGITS(Nd),
      .SCAN_DIV  (ScanDiv),
      .BLANK_LZ  (Blz)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .digits_in (digits_in),
      .dp_in     (dp_in),
      .seg7_sel  (sel_o[i]),
      .seg7_out  (seg_o[i]),
      .dpt_out   (dpt_o[i]),
      .led_com   (com_o[i]),
      .frame_done(fd_o[i])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [6:0] glyph(input int v);
    case (v)
      0:       return 7'b1111110;
      1:       return 7'b0110000;
      2:       return 7'b1101101;
      3:       return 7'b1111001;
      4:       return 7'b0110011;
      5:       return 7'b1011011;
      6:       return 7'b1011111;
      7:       return 7'b1110000;
      8:       return 7'b1111111;
      9:       return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  // Expected display after c edges: c/Period ticks have happened, the position is the tick
  // count modulo the number of active digits, and a wrap lands exactly on a tick edge.
  function automatic exp_t model(input int nd, input bit blz, input int unsigned c,
                                 input logic [23:0] d, input logic [5:0] dp);
    exp_t   e;
    int     ticks;
    int     pos;
    longint upper;
    longint span;
    ticks = int'(c) / Period;
    pos   = ticks % nd;
    upper = longint'(d) >> (4 * pos);
    span  = longint'(1) << (4 * (nd - pos));
    e.sel = 3'(5 - pos);
    e.fd  = (c != 0) && ((int'(c) % Period) == 0) && ((ticks % nd) == 0);
    e.seg = glyph(int'(upper & 15));
    if (blz && pos >= 1 && (upper % span) == 0) e.seg = 7'b0000000;
    e.dpt = dp[pos];
    e.com = 1'b1;
    return e;
  endfunction

  // Drive one cycle's inputs, queue what the monitor must see this cycle, then cross the edge.
  task automatic step(input bit rst, input bit ld, input logic [23:0] d, input logic [5:0] p);
    exp_set_t s;
    reset     = rst;
    load      = ld;
    digits_in = d;
    dp_in     = p;
    if (rst) begin
      cyc   = 0;
      sh_d  = '0;
      sh_dp = '0;
    end
    #1;
    for (int i = 0; i < NumDut; i++) begin
      s[i] = model(nd_of(i), blz_of(i), cyc, sh_d, sh_dp);
    end
    exp_q.push_back(s);
    @(posedge clk);
    #1;
    if (!rst) begin
      cyc++;
      if (ld) begin
        sh_d  = d;
        sh_dp = p;
      end
    end
  endtask

  // Idle cycles with load low and junk on the data inputs.
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      step(1'b0, 1'b0, 24'($urandom), 6'($urandom));
    end
  endtask

  function automatic logic [23:0] rand_digits();
    logic [23:0] v;
    for (int k = 0; k < 6; k++) begin
      v[4*k +: 4] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'd0;
    end
    return v;
  endfunction

  // Monitor
  initial begin
    int       txn;
    exp_set_t s;
    exp_t     act;
    txn = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        s = exp_q.pop_front();
        for (int i = 0; i < NumDut; i++) begin
          act = '{sel: sel_o[i], seg: seg_o[i], dpt: dpt_o[i], fd: fd_o[i], com: com_o[i]};
          checks++;
          if (act !== s[i]) begin
            failures++;
            $display("FAIL dut%0d(nd=%0d,blz=%0d) txn=%0d: got sel=%0d seg=%b dp=%b fd=%b com=%b, want sel=%0d seg=%b dp=%b fd=%b com=%b",
                     i, nd_of(i), blz_of(i), txn, act.sel, act.seg, act.dpt, act.fd, act.com,
                     s[i].sel, s[i].seg, s[i].dpt, s[i].fd, s[i].com);
          end
        end
        txn++;
      end
    end
  end

  // Stimulus
  initial begin
    reset     = 1'b1;
    load      = 1'b0;
    digits_in = '0;
    dp_in     = '0;
    cyc       = 0;
    sh_d      = '0;
    sh_dp     = '0;
    @(posedge clk);
    #1;

    // Reset held, junk on inputs, even with load high.
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 24'($urandom), 6'($urandom));

    // Release; first position change lands on the 4th edge.
    idle(6);

    step(1'b0, 1'b1, 24'h000042, 6'b000010);
    idle(60);
    step(1'b0, 1'b1, 24'h000000, 6'b000000);
    idle(30);
    step(1'b0, 1'b1, 24'h000097, 6'b101010);
    idle(30);
    step(1'b0, 1'b1, 24'h00A0B3, 6'b010101);
    idle(30);

    // Load on a tick edge (the edge after a cycle where cyc%Period == Period-1).
    while ((int'(cyc) % Period) != Period - 1) idle(1);
    step(1'b0, 1'b1, 24'h305001, 6'b100001);
    idle(7);

    // Reset mid-frame, then restart.
    step(1'b1, 1'b0, 24'h0, 6'h0);
    step(1'b1, 1'b0, 24'h0, 6'h0);
    idle(10);

    // Randomised traffic with occasional resets.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 199) == 0) begin
        step(1'b1, 1'($urandom), 24'($urandom), 6'($urandom));
      end else if ($urandom_range(0, 5) == 0) begin
        step(1'b0, 1'b1, rand_digits(), 6'($urandom));
      end else begin
        idle(1);
      end
    end

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d queued entries left, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
